// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// I2C register-access target: 7-bit addressed, 8-bit register pointer with
// auto-increment. The first write byte loads the pointer, later write bytes
// become reg_we strobes, and reads stream reg_rdata MSB first. The target
// never stretches SCL and runs entirely from clk, sampling the bus lines
// through synchronizers.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter logic [7:0] RST_PTR  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
  } state_t;

  // Synchronizer stages and edge history; all idle-high.
  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;
  logic armed;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [6:0] shift_reg, shift_next;
  logic [7:0] tx_reg, tx_next;
  logic       rw_reg, rw_next;
  logic       oe_reg, oe_next;
  logic [7:0] addr_reg, addr_next;
  logic [7:0] wdata_reg, wdata_next;
  logic       we_reg, we_next;
  logic       re_reg, re_next;
  logic       busy_reg, busy_next;
  logic       re_d;
  logic [7:0] rdata_q;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_h <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_h <= 1'b1;
    end else begin
      scl_s1 <= scl;    scl_s2 <= scl_s1; scl_h <= scl_s2;
      sda_s1 <= sda_in; sda_s2 <= sda_s1; sda_h <= sda_s2;
    end
  end

  // After reset the bus is ignored until both lines have been seen idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else if (scl_s2 && scl_h && sda_s2 && sda_h) begin
      armed <= 1'b1;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  assign start_det = armed & scl_s2 & scl_h & sda_h & ~sda_s2;
  assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;
  assign rx_byte   = {shift_reg, sda_s2};

  // Read data arrives the clk after reg_re; hold it for the next byte out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_d    <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      re_d <= re_reg;
      if (re_d) rdata_q <= reg_rdata;
    end
  end

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      shift_reg <= 7'd0;
      tx_reg    <= 8'h00;
      rw_reg    <= 1'b0;
      oe_reg    <= 1'b0;
      addr_reg  <= RST_PTR;
      wdata_reg <= 8'h00;
      we_reg    <= 1'b0;
      re_reg    <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      rw_reg    <= rw_next;
      oe_reg    <= oe_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      we_reg    <= we_next;
      re_reg    <= re_next;
      busy_reg  <= busy_next;
    end
  end

  // Next-state logic: bus conditions first (STOP beats START), then per-state
  // handling of SCL edges. Bits are sampled on rises, SDA drive changes on falls.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    rw_next    = rw_reg;
    oe_next    = oe_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    we_next    = 1'b0;
    re_next    = 1'b0;
    busy_next  = busy_reg;

    // Pointer advances the clk after a write strobe.
    if (we_reg) addr_next = addr_reg + 8'd1;

    if (stop_det) begin
      state_next = IDLE;
      oe_next    = 1'b0;
      busy_next  = 1'b0;
      cnt_next   = 4'd0;
    end else if (start_det) begin
      state_next = ADDR;
      oe_next    = 1'b0;
      cnt_next   = 4'd0;
    end else begin
      case (state_reg)
        IDLE, WAIT: begin
        end
        ADDR: begin
          if (scl_rise) begin
            shift_next = rx_byte[6:0];
            cnt_next   = cnt_reg + 4'd1;
            if (cnt_reg == 4'd7) begin
              // General call (address 0) is never acknowledged.
              if (rx_byte[7:1] == DEV_ADDR && rx_byte[7:1] != 7'd0) begin
                rw_next    = rx_byte[0];
                busy_next  = 1'b1;
                state_next = ADDR_ACK;
              end else begin
                state_next = WAIT;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          // cnt 8: ninth clock not yet seen; cnt 9: ninth rise done.
          if (scl_fall && cnt_reg == 4'd8) begin
            oe_next = 1'b1;
          end else if (scl_rise) begin
            cnt_next = 4'd9;
            if (state_reg == ADDR_ACK && rw_reg) re_next = 1'b1;
          end else if (scl_fall && cnt_reg == 4'd9) begin
            cnt_next = 4'd0;
            if (state_reg == ADDR_ACK && rw_reg) begin
              state_next = RDATA;
              oe_next    = ~rdata_q[7];
              tx_next    = {rdata_q[6:0], 1'b0};
            end else begin
              oe_next    = 1'b0;
              state_next = (state_reg == ADDR_ACK) ? PTR : WDATA;
            end
          end
        end
        PTR: begin
          if (scl_rise) begin
            shift_next = rx_byte[6:0];
            cnt_next   = cnt_reg + 4'd1;
            if (cnt_reg == 4'd7) begin
              addr_next  = rx_byte;
              state_next = PTR_ACK;
            end
          end
        end
        WDATA: begin
          if (scl_rise) begin
            shift_next = rx_byte[6:0];
            cnt_next   = cnt_reg + 4'd1;
            if (cnt_reg == 4'd7) begin
              we_next    = 1'b1;
              wdata_next = rx_byte;
              state_next = WDATA_ACK;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_next = cnt_reg + 4'd1;
            if (cnt_reg == 4'd7) begin
              addr_next  = addr_reg + 8'd1;
              state_next = RDATA_ACK;
            end
          end else if (scl_fall) begin
            oe_next = ~tx_reg[7];
            tx_next = {tx_reg[6:0], 1'b0};
          end
        end
        RDATA_ACK: begin
          if (scl_fall && cnt_reg == 4'd8) begin
            oe_next = 1'b0;
          end else if (scl_rise) begin
            if (!sda_s2) begin
              re_next  = 1'b1;
              cnt_next = 4'd9;
            end else begin
              oe_next    = 1'b0;
              state_next = WAIT;
            end
          end else if (scl_fall && cnt_reg == 4'd9) begin
            cnt_next   = 4'd0;
            state_next = RDATA;
            oe_next    = ~rdata_q[7];
            tx_next    = {rdata_q[6:0], 1'b0};
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign sda_oe    = oe_reg;
  assign reg_addr  = addr_reg;
  assign reg_wdata = wdata_reg;
  assign reg_we    = we_reg;
  assign reg_re    = re_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
// Bench for i2c_target: a timed I2C master drives the bus, a small register
// file answers reg_re/reg_we, and a byte-level model of memory and pointer
// predicts every strobe, read byte and final pointer.
module tb_i2c_target;

  localparam logic [6:0] DEV     = 7'h50;
  localparam logic [7:0] RST_PTR = 8'h5A;
  localparam int         Q       = 60;   // quarter SCL period, ns (24 clk per SCL)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;

  assign sda_line = ~(m_low | sda_oe);

  i2c_target #(.DEV_ADDR(DEV), .RST_PTR(RST_PTR)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Power-on contents of the register file.
  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a * 8'd29) ^ 8'hA5;
  endfunction

  // Register file behind the target plus strobe logs.
  logic [7:0]  dev_mem [256];
  bit          dev_valid [256];
  logic [15:0] we_log [$];
  logic [7:0]  re_log [$];
  int          oe_cycles = 0;
  always @(posedge clk) begin
    if (reg_we) begin
      we_log.push_back({reg_addr, reg_wdata});
      dev_mem[reg_addr] = reg_wdata;
      dev_valid[reg_addr] = 1'b1;
    end
    if (reg_re) begin
      re_log.push_back(reg_addr);
      reg_rdata <= dev_valid[reg_addr] ? dev_mem[reg_addr] : init_val(reg_addr);
    end
    if (sda_oe) oe_cycles <= oe_cycles + 1;
  end

  // SDA drive may only change shortly after an SCL fall.
  realtime last_fall = 0;
  int      timing_bad = 0;
  always @(negedge scl) last_fall = $realtime;
  always @(sda_oe) begin
    if (rst_n === 1'b1 && $realtime > 0) begin
      if (scl) timing_bad++;
      else if ($realtime - last_fall > 40.0) timing_bad++;
    end
  end

  // Reference model.
  logic [7:0] model_mem [256];
  logic [7:0] model_ptr;
  logic [7:0] payload [$];

  int passed = 0, failed = 0, total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---- bit-level master ----
  task automatic bus_start();
    if (!scl) begin
      m_low = 1'b0; #Q; scl = 1'b1; #Q;
    end
    m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
  endtask

  task automatic write_bit(input bit b);
    m_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output bit b);
    m_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda_line; #Q; scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output bit ack);
    bit b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input bit ack);
    bit b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(~ack);
  endtask

  // ---- transaction level ----
  task automatic do_write(input logic [7:0] ptr);
    int n, base;
    bit ack;
    n = payload.size();
    base = we_log.size();
    bus_start();
    write_byte({DEV, 1'b0}, ack);
    check("wr_addr_ack", 32'(ack), 1);
    check("wr_busy", 32'(busy), 1);
    write_byte(ptr, ack);
    check("wr_ptr_ack", 32'(ack), 1);
    for (int i = 0; i < n; i++) begin
      write_byte(payload[i], ack);
      check("wr_data_ack", 32'(ack), 1);
    end
    bus_stop();
    check("wr_strobe_count", 32'(we_log.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < we_log.size(); i++) begin
      check("wr_strobe", 32'(we_log[base + i]), 32'({8'(ptr + 8'(i)), payload[i]}));
    end
    for (int i = 0; i < n; i++) model_mem[8'(ptr + 8'(i))] = payload[i];
    model_ptr = 8'(ptr + 8'(n));
    check("wr_ptr_after", 32'(reg_addr), 32'(model_ptr));
    check("wr_busy_after_stop", 32'(busy), 0);
    $display("write ptr=%02h bytes=%0d next_ptr=%02h", ptr, n, model_ptr);
  endtask

  task automatic do_read(input logic [7:0] ptr, input int n, input bit set_ptr);
    int base;
    bit ack;
    logic [7:0] p0, d;
    base = re_log.size();
    p0 = set_ptr ? ptr : model_ptr;
    bus_start();
    if (set_ptr) begin
      write_byte({DEV, 1'b0}, ack);
      check("rd_waddr_ack", 32'(ack), 1);
      write_byte(ptr, ack);
      check("rd_ptr_ack", 32'(ack), 1);
      bus_start();
    end
    write_byte({DEV, 1'b1}, ack);
    check("rd_addr_ack", 32'(ack), 1);
    for (int i = 0; i < n; i++) begin
      read_byte(d, i != n - 1);
      check("rd_data", 32'(d), 32'(model_mem[8'(p0 + 8'(i))]));
    end
    check("rd_oe_after_nack", 32'(sda_oe), 0);
    bus_stop();
    check("rd_strobe_count", 32'(re_log.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < re_log.size(); i++) begin
      check("rd_strobe_addr", 32'(re_log[base + i]), 32'(8'(p0 + 8'(i))));
    end
    model_ptr = 8'(p0 + 8'(n));
    check("rd_ptr_after", 32'(reg_addr), 32'(model_ptr));
    $display("read ptr=%02h bytes=%0d next_ptr=%02h", p0, n, model_ptr);
  endtask

  // Bound on total run time.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_we, base_re, oe0;
    bit ack, b;
    logic [7:0] d;

    for (int i = 0; i < 256; i++) model_mem[i] = init_val(8'(i));
    model_ptr = RST_PTR;

    // Reset state.
    repeat (4) @(negedge clk);
    #2;
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_reg_we", 32'(reg_we), 0);
    check("rst_reg_re", 32'(reg_re), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_reg_wdata", 32'(reg_wdata), 0);
    check("rst_reg_addr", 32'(reg_addr), 32'(RST_PTR));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #2;

    // Directed write and read.
    payload = '{8'h55, 8'hAA};
    do_write(8'h10);
    do_read(8'h20, 2, 1'b1);

    // Address mismatch.
    base_we = we_log.size();
    base_re = re_log.size();
    oe0 = oe_cycles;
    bus_start();
    write_byte(8'hB0, ack);
    check("mm_addr_nack", 32'(ack), 0);
    check("mm_busy", 32'(busy), 0);
    write_byte(8'h01, ack);
    check("mm_data_nack", 32'(ack), 0);
    bus_stop();
    check("mm_oe_cycles", 32'(oe_cycles - oe0), 0);
    check("mm_no_we", 32'(we_log.size() - base_we), 0);
    check("mm_no_re", 32'(re_log.size() - base_re), 0);
    check("mm_ptr_kept", 32'(reg_addr), 32'(model_ptr));
    $display("mismatch addr=58 no response");

    // Pointer wrap.
    payload = '{8'h01, 8'h02};
    do_write(8'hFF);

    // Abort mid data byte.
    base_we = we_log.size();
    bus_start();
    write_byte({DEV, 1'b0}, ack);
    check("ab_addr_ack", 32'(ack), 1);
    write_byte(8'h40, ack);
    check("ab_ptr_ack", 32'(ack), 1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    bus_stop();
    model_ptr = 8'h40;
    check("ab_no_we", 32'(we_log.size() - base_we), 0);
    check("ab_busy", 32'(busy), 0);
    check("ab_ptr", 32'(reg_addr), 32'h40);
    $display("abort after 4 data bits ptr=40");

    // Randomized traffic.
    for (int k = 0; k < 8; k++) begin
      logic [7:0] p;
      int n;
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
        do_write(p);
      end else begin
        do_read(p, n, $urandom_range(0, 1) == 1 || k == 0);
      end
    end

    // Reset mid read byte: target is driving a zero bit when reset hits.
    payload = '{8'h00};
    do_write(8'h33);
    bus_start();
    write_byte({DEV, 1'b0}, ack);
    write_byte(8'h33, ack);
    bus_start();
    write_byte({DEV, 1'b1}, ack);
    check("rr_addr_ack", 32'(ack), 1);
    read_bit(b); read_bit(b); read_bit(b);
    check("rr_oe_before", 32'(sda_oe), 1);
    rst_n = 1'b0;
    #1;
    check("rr_oe_at_reset", 32'(sda_oe), 0);
    check("rr_ptr_at_reset", 32'(reg_addr), 32'(RST_PTR));
    check("rr_busy_at_reset", 32'(busy), 0);
    m_low = 1'b0;
    #20;
    scl = 1'b1;
    #40;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    model_ptr = RST_PTR;
    $display("reset mid read released");
    do_read(8'h00, 1, 1'b0);

    check("sda_oe_timing", 32'(timing_bad), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 The block SHALL provide parameter DEV_ADDR, default 7'h50, the 7-bit I2C address the block answers to.
REQ-002 The block SHALL provide parameter RST_PTR, default 8'h00, the register pointer value after reset.
REQ-003 clk  input  1  system clock; SHALL be at least 20x the bus SCL frequency.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 scl  input  1  I2C clock from the bus, asynchronous to clk.
REQ-006 sda_in  input  1  I2C data read back from the bus pin, asynchronous to clk.
REQ-007 sda_oe  output  1  open-drain drive: 1 pulls SDA low, 0 releases it.
REQ-008 reg_addr  output  8  current register pointer.
REQ-009 reg_wdata  output  8  write data, valid while reg_we=1.
REQ-010 reg_we  output  1  one-clk write strobe.
REQ-011 reg_re  output  1  one-clk read strobe.
REQ-012 reg_rdata  input  8  read data, valid on the clk after reg_re.
REQ-013 busy  output  1  high from an address-matched START until STOP.

Function
REQ-014 scl and sda_in SHALL each pass through a 2-flop synchronizer plus 1 history flop; edges are detected on the synchronized signals, giving a pin-to-detect latency of 3 clk.
REQ-015 START (SDA falls while SCL high) SHALL enter ADDR from any state, including mid-byte (repeated START), and SHALL clear the bit counter.
REQ-016 STOP (SDA rises while SCL high) SHALL enter IDLE from any state, set sda_oe=0 and clear busy within 1 clk; reg_addr SHALL be retained.
REQ-017 States SHALL be: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
REQ-018 The block SHALL sample SDA only on the SCL rising edge and change sda_oe only on the SCL falling edge (plus REQ-016); data bits are shifted MSB first.
REQ-019 ADDR: after 8 bits, if bits[7:1]==DEV_ADDR, the block SHALL latch the R/W bit, set busy, and pull SDA low for the 9th clock (ADDR_ACK); on a mismatch it SHALL enter WAIT and leave sda_oe=0.
REQ-020 Write (R/W=0): the first data byte SHALL load reg_addr and be ACKed (PTR, PTR_ACK); reg_we SHALL NOT pulse for this byte.
REQ-021 Each later byte SHALL be ACKed and produce one reg_we pulse on the 8th SCL rising edge, with reg_wdata=byte and reg_addr=current pointer; reg_addr SHALL increment the clk after reg_we.
REQ-022 Read (R/W=1): reg_re SHALL pulse on the SCL rising edge of the ADDR_ACK bit; reg_rdata SHALL be captured the next clk; the MSB SHALL be driven on the falling edge that ends ACK.
REQ-023 After each read byte, reg_addr SHALL increment; in RDATA_ACK, sda_oe SHALL be 0.
REQ-024 A master ACK (SDA=0 at the 9th rise) SHALL pulse reg_re for the next byte on that rising edge.
REQ-025 A master NACK SHALL enter WAIT, with sda_oe=0 until the next START or STOP.
REQ-026 reg_addr SHALL wrap from 8'hFF to 8'h00.
REQ-027 If START and STOP are detected in the same clk, STOP SHALL win.
REQ-028 The block SHALL NOT stretch the clock, and SHALL ignore general call (address 0).
REQ-029 WAIT SHALL ignore all SCL edges until the next START or STOP.

Reset
REQ-030 While rst_n=0, the outputs SHALL be: sda_oe=0, reg_we=0, reg_re=0, busy=0, reg_wdata=0, reg_addr=RST_PTR; the state SHALL be IDLE and the synchronizers SHALL be 1.
REQ-031 After reset release, the block SHALL ignore the bus until the first START detected with both synchronized lines having been high for 1 clk.
REQ-032 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously).

Verification
REQ-033 Write: START, 0xA0, 0x10, 0x55, 0xAA, STOP -> three ACKs plus address ACK; reg_we pulses with (addr 0x10, data 0x55) then (0x11, 0xAA); reg_addr=0x12 after STOP.
REQ-034 Read: START, 0xA0, 0x20, repeated START, 0xA1, read 2 bytes with ACK then NACK, STOP -> reg_re pulses at 0x20 and 0x21; SDA carries reg_rdata MSB first; reg_addr=0x22; sda_oe=0 after NACK.
REQ-035 Address mismatch: START, 0xB0, 0x01, STOP -> sda_oe stays 0 throughout, no reg_we or reg_re, busy=0.
REQ-036 Pointer wrap: write pointer 0xFF, then data 0x01, 0x02 -> reg_we at addr 0xFF then 0x00.
REQ-037 Abort: STOP after 4 bits of a data byte -> no reg_we, IDLE; rst_n pulse mid-read-byte -> sda_oe=0 at once, reg_addr=RST_PTR.
REQ-038 Timing: at clk=50 MHz and SCL=400 kHz, every sda_oe change occurs within 4 clk after the SCL falling edge and never while SCL is high, except on STOP release.
